// File: rtl/ahfp_addsub_pipe.sv
// Pipelined IEEE-754-style floating-point adder/subtractor with runtime add/sub select,
// round-to-nearest-even, flush-to-zero denormals, special values and status flags.
module ahfp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic                   in_valid,
  input  logic                   add_sub,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   nan
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MF   = MAN_W + 4;          // hidden, fraction, guard, round, sticky
  localparam int SW   = MAN_W + 5;          // sum with carry-out
  localparam int EW   = EXP_W + 2;          // signed exponent with range headroom
  localparam int LZ_W = $clog2(MF + 1);

  localparam logic [EW-1:0]        ONE_E  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] E_INF  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};

  // Leading-zero count; the highest set bit overwrites lower ones.
  function automatic logic [LZ_W-1:0] lzc(input logic [MF-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(MF);
    for (int i = 0; i < MF; i++) begin
      n = v[i] ? LZ_W'(MF - 1 - i) : n;
    end
    return n;
  endfunction

  // ---------------- rank 0: input capture ----------------
  logic         v0_r, as0_r;
  logic [W-1:0] a0_r, b0_r;

  // Input register rank
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v0_r  <= 1'b0;
      as0_r <= 1'b0;
      a0_r  <= {W{1'b0}};
      b0_r  <= {W{1'b0}};
    end else if (clk_en) begin
      v0_r  <= in_valid;
      as0_r <= add_sub;
      a0_r  <= dataa;
      b0_r  <= datab;
    end
  end

  // ---------------- stage 1: unpack / swap / align ----------------
  logic               sa_s, sb_s;
  logic [EXP_W-1:0]   ea_s, eb_s;
  logic [MAN_W-1:0]   fa_s, fb_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [MAN_W:0]     ma_s, mb_s;
  logic [W-2:0]       mag_a_s, mag_b_s;
  logic               swap_s;
  logic               sl_s;
  logic [EXP_W-1:0]   el_s, es_s, diff_s;
  logic [MAN_W:0]     ml_s, msm_s;
  logic [MF-1:0]      ext_s, al_s;
  logic               lost_s;

  assign sa_s     = a0_r[W-1];
  assign sb_s     = b0_r[W-1] ^ ~as0_r;
  assign ea_s     = a0_r[W-2:MAN_W];
  assign eb_s     = b0_r[W-2:MAN_W];
  assign fa_s     = a0_r[MAN_W-1:0];
  assign fb_s     = b0_r[MAN_W-1:0];
  assign a_zero_s = (ea_s == {EXP_W{1'b0}});
  assign b_zero_s = (eb_s == {EXP_W{1'b0}});
  assign a_inf_s  = (ea_s == {EXP_W{1'b1}}) && (fa_s == {MAN_W{1'b0}});
  assign b_inf_s  = (eb_s == {EXP_W{1'b1}}) && (fb_s == {MAN_W{1'b0}});
  assign a_nan_s  = (ea_s == {EXP_W{1'b1}}) && (fa_s != {MAN_W{1'b0}});
  assign b_nan_s  = (eb_s == {EXP_W{1'b1}}) && (fb_s != {MAN_W{1'b0}});
  assign ma_s     = a_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, fa_s};
  assign mb_s     = b_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, fb_s};
  assign mag_a_s  = a_zero_s ? {(W-1){1'b0}} : a0_r[W-2:0];
  assign mag_b_s  = b_zero_s ? {(W-1){1'b0}} : b0_r[W-2:0];
  assign swap_s   = (mag_b_s > mag_a_s);

  // Order operands so the larger magnitude is on the "l" side
  always_comb begin
    sl_s  = sa_s;
    el_s  = ea_s;
    ml_s  = ma_s;
    es_s  = eb_s;
    msm_s = mb_s;
    if (swap_s) begin
      sl_s  = sb_s;
      el_s  = eb_s;
      ml_s  = mb_s;
      es_s  = ea_s;
      msm_s = ma_s;
    end else begin
      sl_s  = sa_s;
      el_s  = ea_s;
      ml_s  = ma_s;
      es_s  = eb_s;
      msm_s = mb_s;
    end
  end

  // Bits shifted past the sticky position are folded back into it.
  assign diff_s = el_s - es_s;
  assign ext_s  = {msm_s, 3'b000};
  assign lost_s = |(ext_s & ~({MF{1'b1}} << diff_s));
  assign al_s   = (ext_s >> diff_s) | {{(MF-1){1'b0}}, lost_s};

  logic             v1_r, s1_r, sub1_r, zs1_r, nan1_r, inf1_r, infs1_r;
  logic [EXP_W-1:0] e1_r;
  logic [MF-1:0]    ml1_r, ms1_r;

  // Stage 1 register rank
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v1_r    <= 1'b0;
      s1_r    <= 1'b0;
      sub1_r  <= 1'b0;
      zs1_r   <= 1'b0;
      nan1_r  <= 1'b0;
      inf1_r  <= 1'b0;
      infs1_r <= 1'b0;
      e1_r    <= {EXP_W{1'b0}};
      ml1_r   <= {MF{1'b0}};
      ms1_r   <= {MF{1'b0}};
    end else if (clk_en) begin
      v1_r    <= v0_r;
      s1_r    <= sl_s;
      sub1_r  <= sa_s ^ sb_s;
      zs1_r   <= sa_s & sb_s;
      nan1_r  <= a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (sa_s ^ sb_s));
      inf1_r  <= a_inf_s | b_inf_s;
      infs1_r <= a_inf_s ? sa_s : sb_s;
      e1_r    <= el_s;
      ml1_r   <= {ml_s, 3'b000};
      ms1_r   <= al_s;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [SW-1:0]    sum_s;
  logic             v2_r, s2_r, zs2_r, nan2_r, inf2_r, infs2_r;
  logic [EXP_W-1:0] e2_r;
  logic [SW-1:0]    sum2_r;

  assign sum_s = sub1_r ? ({1'b0, ml1_r} - {1'b0, ms1_r}) : ({1'b0, ml1_r} + {1'b0, ms1_r});

  // Stage 2 register rank
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v2_r    <= 1'b0;
      s2_r    <= 1'b0;
      zs2_r   <= 1'b0;
      nan2_r  <= 1'b0;
      inf2_r  <= 1'b0;
      infs2_r <= 1'b0;
      e2_r    <= {EXP_W{1'b0}};
      sum2_r  <= {SW{1'b0}};
    end else if (clk_en) begin
      v2_r    <= v1_r;
      s2_r    <= s1_r;
      zs2_r   <= zs1_r;
      nan2_r  <= nan1_r;
      inf2_r  <= inf1_r;
      infs2_r <= infs1_r;
      e2_r    <= e1_r;
      sum2_r  <= sum_s;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic [LZ_W-1:0] lz_s;
  logic [MF-1:0]   nm_s;
  logic [EW-1:0]   ne_s;

  assign lz_s = lzc(sum2_r[MF-1:0]);

  // Carry-out shifts right with sticky; otherwise left-justify the leading one
  always_comb begin
    nm_s = sum2_r[MF-1:0];
    ne_s = {2'b00, e2_r};
    if (sum2_r[SW-1]) begin
      nm_s = {sum2_r[SW-1:2], sum2_r[1] | sum2_r[0]};
      ne_s = {2'b00, e2_r} + ONE_E;
    end else begin
      nm_s = sum2_r[MF-1:0] << lz_s;
      ne_s = {2'b00, e2_r} - EW'(lz_s);
    end
  end

  logic                 v3_r, s3_r, zf3_r, zs3_r, nan3_r, inf3_r, infs3_r;
  logic signed [EW-1:0] e3_r;
  logic [MF-1:0]        m3_r;

  // Stage 3 register rank
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v3_r    <= 1'b0;
      s3_r    <= 1'b0;
      zf3_r   <= 1'b0;
      zs3_r   <= 1'b0;
      nan3_r  <= 1'b0;
      inf3_r  <= 1'b0;
      infs3_r <= 1'b0;
      e3_r    <= E_ZERO;
      m3_r    <= {MF{1'b0}};
    end else if (clk_en) begin
      v3_r    <= v2_r;
      s3_r    <= s2_r;
      zf3_r   <= (sum2_r == {SW{1'b0}});
      zs3_r   <= zs2_r;
      nan3_r  <= nan2_r;
      inf3_r  <= inf2_r;
      infs3_r <= infs2_r;
      e3_r    <= ne_s;
      m3_r    <= nm_s;
    end
  end

  // ---------------- stage 4: round / pack ----------------
  logic                 inc_s;
  logic [MAN_W+1:0]     rnd_s;
  logic signed [EW-1:0] fe_s;
  logic [W-1:0]         res_s;
  logic                 ovf_s, unf_s, zro_s, nan_s;

  assign inc_s = m3_r[2] & (m3_r[1] | m3_r[0] | m3_r[3]);
  assign rnd_s = {1'b0, m3_r[MF-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
  // Top two rounded bits are 01 normally and 10 after rounding carry: adds 0 or +1.
  assign fe_s  = e3_r + EW'(rnd_s[MAN_W+1:MAN_W]) - ONE_E;

  // Special values first, then exponent range, then the normal packed result
  always_comb begin
    res_s = {s3_r, fe_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
    ovf_s = 1'b0;
    unf_s = 1'b0;
    zro_s = 1'b0;
    nan_s = 1'b0;
    if (nan3_r) begin
      res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nan_s = 1'b1;
    end else if (inf3_r) begin
      res_s = {infs3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zf3_r) begin
      res_s = {zs3_r, {(W-1){1'b0}}};
      zro_s = 1'b1;
    end else if (fe_s >= E_INF) begin
      res_s = {s3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_s = 1'b1;
    end else if (fe_s <= E_ZERO) begin
      res_s = {s3_r, {(W-1){1'b0}}};
      unf_s = 1'b1;
      zro_s = 1'b1;
    end else begin
      res_s = {s3_r, fe_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
    end
  end

  // Output rank; bubbles clear out_valid but leave result and flags untouched
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
      nan       <= 1'b0;
    end else if (clk_en) begin
      out_valid <= v3_r;
      if (v3_r) begin
        result    <= res_s;
        overflow  <= ovf_s;
        underflow <= unf_s;
        zero      <= zro_s;
        nan       <= nan_s;
      end
    end
  end

endmodule

// File: doc/ahfp_addsub_pipe.md
Name: ahfp_addsub_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor.
- Generalises the team's combinational single-precision subtractor:
  - runtime add/sub select
  - parametrised exponent and mantissa widths
  - round-to-nearest-even
  - special-value handling and status flags
  - valid-tagged 4-stage pipeline with clock enable
- Sits in the datapath wherever ahfp_* arithmetic units are instantiated; one operation accepted per enabled cycle.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit not stored).

Ports:
- clock, input, 1, rising-edge clock.
- aclr, input, 1, asynchronous active-high reset.
- clk_en, input, 1, 1 = pipeline advances; 0 = all stages hold.
- in_valid, input, 1, dataa/datab/add_sub carry a valid operation this cycle.
- add_sub, input, 1, 1 = dataa+datab, 0 = dataa-datab.
- dataa, input, 1+EXP_W+MAN_W, operand A {sign, exp, frac}.
- datab, input, 1+EXP_W+MAN_W, operand B.
- out_valid, output, 1, result/flags valid.
- result, output, 1+EXP_W+MAN_W, rounded result.
- overflow, output, 1, finite result rounded beyond max normal.
- underflow, output, 1, nonzero result flushed to zero.
- zero, output, 1, result is ±0.
- nan, output, 1, result is NaN.

Behaviour:
- Clock and reset: one clock (clock); reset aclr is asynchronous, active-high.
- aclr asserted:
  - all pipeline registers, out_valid, result and all flags go to 0 immediately.
  - In-flight operations are discarded.
  - First capture after release occurs on the first rising edge with aclr low and clk_en high.
- Latency and throughput:
  - Exactly 4 enabled cycles from input to output.
  - An operation presented with in_valid=1 on enabled edge N appears with out_valid=1 after enabled edge N+4.
  - Throughput is 1 per enabled cycle.
- in_valid=0 produces a bubble: out_valid=0 at the corresponding slot; result/flags hold their previous values.
- clk_en=0: every stage register, including out_valid and outputs, holds. No operation is lost or duplicated.
- Stage 1 (unpack/align):
  - Effective B sign = datab sign XOR ~add_sub.
  - Exponent 0 inputs are treated as zero (denormal flush-to-zero).
  - Swap so |A| >= |B|; ties on exponent are broken by fraction.
  - Shift the smaller mantissa right by the exponent difference into a MAN_W+4 field: hidden bit, fraction, guard, round, sticky.
  - Shifts >= MAN_W+3 leave only the sticky bit (set if B nonzero).
- Stage 2 (add): same effective signs add, otherwise subtract the smaller from the larger; width MAN_W+5, no wrap.
- Stage 3 (normalise):
  - On carry-out: shift right 1 (sticky ORed), exponent +1.
  - Otherwise a leading-zero count shifts left, exponent reduced by that count.
  - Exponent is carried in EXP_W+2 signed bits so over/underrange is detectable.
- Stage 4 (round/pack):
  - RNE: increment when G & (R | S | lsb).
  - Mantissa overflow from rounding: exponent +1, fraction 0.
  - Final exponent >= 2^EXP_W-1: ±infinity, overflow=1.
  - Final exponent <= 0: ±0, underflow=1, zero=1.
- Special values:
  - Any NaN input, or inf-inf of effective opposite signs: canonical NaN {0, all-ones, 1, zeros}, nan=1.
  - inf ± finite: that inf (flags 0).
  - Exact-zero difference: +0. (-0)+(-0) gives -0.
- Flags are mutually exclusive except underflow implies zero.

Test Plan:
1. add_sub=1, 0x3F800000 + 0x40000000 -> after 4 cycles result=0x40400000, out_valid=1, all flags 0.
2. add_sub=0, 0x3F800000 - 0x3F800000 -> 0x00000000, zero=1. add_sub=1, 0x80000000 + 0x80000000 -> 0x80000000, zero=1.
3. RNE ties:
   - 0x3F800000 + 0x33800000 -> 0x3F800000.
   - 0x3F800001 + 0x33800000 -> 0x3F800002.
   - 0x3F800000 - 0x33000000 -> 0x3F800000.
4. Specials:
   - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
   - 0x7F800000 - 0x7F800000 -> 0x7FC00000, nan=1.
   - 0x00800000 - 0x00800001 -> 0x80000000, underflow=1, zero=1.
5. Stream of 8 back-to-back ops with clk_en low for 3 cycles mid-stream -> exactly 8 out_valid pulses, in order, values unchanged, outputs frozen during the stall.
6. aclr pulsed (not clock-aligned) with 3 ops in flight -> outputs and out_valid go 0 immediately. No stale op emerges. A new op issued after release -> correct result 4 enabled cycles later.
